// File: rtl/mult_div_unit_if.sv
// Operand, start and result bundle between the execute stage and the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed MUL/DIV; RDY pulses WIDTH+1 cycles after the start edge, for every operand value.
// No backpressure: result/exception hold until the next completion; any new start aborts and restarts.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clock,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state, state_nxt;
    logic               start_mul, start_div, start, last_iter;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] work_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               neg_q, div_zero_q, div_ovf_q;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, work_nxt, prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic               mul_exc;

    // Simultaneous MULT and DIV is not a request at all, in any state.
    assign start_mul = bus.ctrl_MULT & ~bus.ctrl_DIV;
    assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign start     = start_mul | start_div;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start_mul) begin
            state_nxt = S_MUL;
        end else if (start_div) begin
            state_nxt = S_DIV;
        end else begin
            case (state)
                S_MUL, S_DIV: if (last_iter) state_nxt = S_DONE;
                S_DONE:       state_nxt = S_IDLE;
                default:      state_nxt = state;
            endcase
        end
    end

    // Both ops run on magnitudes; the sign is applied once on the final iteration.
    always_comb begin
        mag_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
        mag_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

        mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt = {mul_sum, work_q[WIDTH-1:1]};

        // work_q = {remainder, dividend/quotient}; restoring step.
        rem_sh  = work_q[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, opnd_q};
        div_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                              : {diff[WIDTH-1:0],   work_q[WIDTH-2:0], 1'b1};

        work_nxt = (state == S_DIV) ? div_nxt : mul_nxt;
        prod_s   = neg_q ? -work_nxt : work_nxt;
        quot_s   = neg_q ? -work_nxt[WIDTH-1:0] : work_nxt[WIDTH-1:0];
        mul_exc  = ~(&prod_s[2*WIDTH-1:WIDTH-1]) & (|prod_s[2*WIDTH-1:WIDTH-1]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            work_q     <= '0;
            opnd_q     <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            result_q   <= '0;
            exc_q      <= 1'b0;
        end else if (start) begin
            cnt_q      <= '0;
            work_q     <= {{WIDTH{1'b0}}, (start_mul ? mag_b : mag_a)};
            opnd_q     <= start_mul ? mag_a : mag_b;
            neg_q      <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            div_zero_q <= start_div && (bus.data_operandB == '0);
            div_ovf_q  <= start_div && (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                                    && (bus.data_operandB == '1);
        end else if (state == S_MUL || state == S_DIV) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            work_q <= work_nxt;
            if (last_iter) begin
                if (state == S_MUL) begin
                    result_q <= prod_s[WIDTH-1:0];
                    exc_q    <= mul_exc;
                end else begin
                    result_q <= div_zero_q ? '0 : quot_s;
                    exc_q    <= div_zero_q | div_ovf_q;
                end
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state == S_DONE);
    assign bus.busy           = (state != S_IDLE);
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mult_div_unit_if #(.WIDTH(W)) bus ();
    mult_div_unit #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_res;
    logic        last_exc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ref_model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic e);
        longint p;
        if (!is_div) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(r)));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = 32'($signed(a) / $signed(b));
            e = 1'b0;
        end
    endtask

    // Called just after a falling edge; returns 1 ns after the start edge.
    task automatic start_op(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = ~is_div;
        bus.ctrl_DIV      = is_div;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Samples n cycles after the start edge; rdy_at==0 means no completion expected in the window.
    task automatic watch(input int n, input int rdy_at, input logic [31:0] er, input logic ee,
                         input string tag);
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            check({tag, " busy"}, 32'(bus.busy), 32'(rdy_at == 0 || k <= rdy_at));
            check({tag, " rdy"}, 32'(bus.data_resultRDY), 32'(k == rdy_at));
            if (k == rdy_at) begin
                last_res = er;
                last_exc = ee;
            end
            check({tag, " result"}, bus.data_result, last_res);
            check({tag, " exc"}, 32'(bus.data_exception), 32'(last_exc));
        end
    endtask

    task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [31:0] r;
        logic        e;
        ref_model(is_div, a, b, r, e);
        start_op(is_div, a, b);
        watch(34, 33, r, e, tag);
    endtask

    function automatic logic [31:0] rand_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = 32'($urandom_range(0, 200)) - 32'd100;
            2: case ($urandom_range(0, 4))
                   0:       v = 32'd0;
                   1:       v = 32'd1;
                   2:       v = 32'hFFFF_FFFF;
                   3:       v = 32'h8000_0000;
                   default: v = 32'h7FFF_FFFF;
               endcase
            default: v = 32'($urandom_range(0, 65535));
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] r;
        logic        e;
        reset             = 1'b1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        last_res          = '0;
        last_exc          = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset rdy", 32'(bus.data_resultRDY), 32'd0);
        check("reset result", bus.data_result, 32'd0);
        check("reset exc", 32'(bus.data_exception), 32'd0);
        reset = 1'b0;

        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, "mul 7x-3");
        run_op(1'b0, 32'h4000_0000, 32'd4, "mul ovf");
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul -1x-1");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        run_op(1'b1, 32'd100, 32'hFFFF_FFF6, "div 100/-10");
        run_op(1'b1, 32'd5, 32'd0, "div by zero");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div intmin/-1");
        run_op(1'b0, 32'h8000_0000, 32'd1, "mul intmin x1");

        // Both starts together: ignored entirely, outputs hold.
        bus.ctrl_MULT     = 1'b1;
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = 32'd6;
        bus.data_operandB = 32'd7;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clock);
            check("both busy", 32'(bus.busy), 32'd0);
            check("both rdy", 32'(bus.data_resultRDY), 32'd0);
            check("both result", bus.data_result, last_res);
        end

        // Restart mid-operation: only the second op completes.
        start_op(1'b0, 32'd3, 32'd3);
        watch(10, 0, 32'd0, 1'b0, "abort mul");
        run_op(1'b1, 32'd9, 32'd3, "restart div");

        // Start landing in the DONE cycle: that RDY still fires, then the new op runs in full.
        ref_model(1'b0, 32'd11, 32'd13, r, e);
        start_op(1'b0, 32'd11, 32'd13);
        watch(33, 33, r, e, "done mul");
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, "after done div");

        // Reset mid-operation.
        start_op(1'b0, 32'd5, 32'd6);
        watch(19, 0, 32'd0, 1'b0, "pre reset");
        reset = 1'b1;
        @(negedge clock);
        reset    = 1'b0;
        last_res = '0;
        last_exc = 1'b0;
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset rdy", 32'(bus.data_resultRDY), 32'd0);
        check("midreset result", bus.data_result, 32'd0);
        check("midreset exc", 32'(bus.data_exception), 32'd0);
        run_op(1'b0, 32'd2, 32'd2, "post reset mul");

        for (int i = 0; i < 30; i++) begin
            run_op(1'($urandom_range(0, 1)), rand_opnd(), rand_opnd(), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
